// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared types and constants for the 8259A-subset master interrupt
// controller (pic_master and its helpers).
//   state_t : request handshake state towards the CPU (IDLE / REQ)
//   init_t  : initialisation word sequencing (READY / WAIT_ICW2 / WAIT_ICW4)
//   EOI_NS  : OCW2 d[7:5] code for a non-specific end of interrupt
//   EOI_SP  : OCW2 d[7:5] code for a specific end of interrupt
// ---------------------------------------------------------------------------
package pic_pkg;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    typedef enum logic [1:0] {
        READY,
        WAIT_ICW2,
        WAIT_ICW4
    } init_t;

    localparam logic [2:0] EOI_NS = 3'b001;
    localparam logic [2:0] EOI_SP = 3'b011;

endpackage

// File: rtl/pic_master_if.sv
// ---------------------------------------------------------------------------
// pic_master_if
// Bus bundle between the CPU side and the interrupt controller.
//   io_en/io_a0/io_wr/io_wdata : port 20h/21h access strobe, address, dir, data
//   io_rdata                   : registered read data
//   irq_in                     : raw IRQ lines
//   intr/inta/vector           : interrupt request, acknowledge, vector
// Modports:
//   master : CPU / system side (drives accesses, IRQ lines and inta)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface pic_master_if;

    logic       io_en;
    logic       io_a0;
    logic       io_wr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic [7:0] irq_in;
    logic       intr;
    logic       inta;
    logic [7:0] vector;

    modport master (
        output io_en, io_a0, io_wr, io_wdata, irq_in, inta,
        input  io_rdata, intr, vector
    );

    modport slave (
        input  io_en, io_a0, io_wr, io_wdata, irq_in, inta,
        output io_rdata, intr, vector
    );

endinterface

// File: rtl/pic_prio8.sv
// ---------------------------------------------------------------------------
// pic_prio8
// 8-bit priority encoder, lowest set index wins (index 0 = highest priority).
//   req   in  8  request vector
//   valid out 1  at least one request bit is set
//   idx   out 3  index of the lowest set bit (0 when none is set)
// ---------------------------------------------------------------------------
module pic_prio8 (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pic_master.sv
// ---------------------------------------------------------------------------
// pic_master
// 8259A-subset master interrupt controller: latches eight edge-triggered
// IRQ lines, arbitrates them by fixed priority (IRQ0 highest), raises intr
// to the CPU and returns the vector on acknowledge. Programmed through
// ports 20h (io_a0=0, ICW1/OCW2/OCW3) and 21h (io_a0=1, ICW2/ICW4/IMR).
// Ports:
//   clock  in  CPU host clock, posedge
//   resetn in  synchronous reset, active-low
//   bus    slave modport of pic_master_if (port access, IRQs, intr/inta/vector)
// Parameters:
//   VEC_RESET  vector base after reset (bits [2:0] ignored)
//   IMR_RESET  mask register value after reset
// Build option:
//   PIC_AUTO_EOI_EN  when defined, ICW4 bit1 enables automatic EOI
//                    (acknowledge does not set ISR).
// ---------------------------------------------------------------------------
module pic_master
    import pic_pkg::*;
#(
    parameter logic [7:0] VEC_RESET = 8'h08,
    parameter logic [7:0] IMR_RESET = 8'h00
) (
    input logic        clock,
    input logic        resetn,
    pic_master_if.slave bus
);

    logic [7:0] irq_prev, irr, isr, imr, rdata, vec;
    logic [7:0] pend, edges, eoi_clr, irr_clr, isr_set;
    logic [4:0] base;
    logic       sel, ic4, aeoi;
    logic       win_valid, isr_valid, eligible, ack, ack_hit;
    logic [2:0] win_idx, isr_idx;
    logic       cmd_wr, data_wr, rd_strobe, icw1, ocw2, ocw3;
    state_t     state, state_next;
    init_t      init;

    assign edges     = bus.irq_in & ~irq_prev;
    assign pend      = irr & ~imr;
    assign cmd_wr    = bus.io_en & bus.io_wr & ~bus.io_a0;
    assign data_wr   = bus.io_en & bus.io_wr & bus.io_a0;
    assign rd_strobe = bus.io_en & ~bus.io_wr;
    assign icw1      = cmd_wr & bus.io_wdata[4];
    assign ocw2      = cmd_wr & (bus.io_wdata[4:3] == 2'b00);
    assign ocw3      = cmd_wr & (bus.io_wdata[4:3] == 2'b01);

    pic_prio8 u_prio_pend (.req(pend), .valid(win_valid), .idx(win_idx));
    pic_prio8 u_prio_isr  (.req(isr),  .valid(isr_valid), .idx(isr_idx));

    // The lowest in-service index tells whether anything of equal or
    // higher priority than the winner is still being serviced.
    assign eligible = win_valid && (init == READY) &&
                      !(isr_valid && (isr_idx <= win_idx));
    assign ack      = bus.inta && (state == REQ);
    assign ack_hit  = ack && eligible;

`ifndef PIC_AUTO_EOI_EN
    assign aeoi = 1'b0;
`endif

    // Request handshake: leave REQ on acknowledge or when the winner
    // disappears (masked, serviced elsewhere or re-initialised).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (eligible) state_next = REQ;
            REQ:     if (ack || !eligible) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (icw1) state_next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // ISR clear/set masks; clears are applied before sets so an EOI and an
    // acknowledge in the same cycle both take effect.
    always_comb begin
        eoi_clr = 8'h00;
        irr_clr = 8'h00;
        isr_set = 8'h00;
        if (ocw2 && bus.io_wdata[7:5] == EOI_NS) eoi_clr[isr_idx] = isr_valid;
        if (ocw2 && bus.io_wdata[7:5] == EOI_SP) eoi_clr[bus.io_wdata[2:0]] = 1'b1;
        if (ack_hit) begin
            irr_clr[win_idx] = 1'b1;
            isr_set[win_idx] = ~aeoi;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            irq_prev <= 8'h00;
            irr      <= 8'h00;
            isr      <= 8'h00;
            imr      <= IMR_RESET;
            base     <= VEC_RESET[7:3];
            vec      <= VEC_RESET;
            rdata    <= 8'h00;
            sel      <= 1'b0;
            ic4      <= 1'b0;
            init     <= READY;
`ifdef PIC_AUTO_EOI_EN
            aeoi     <= 1'b0;
`endif
        end else begin
            irq_prev <= bus.irq_in;
            if (icw1) begin
                irr  <= 8'h00;
                isr  <= 8'h00;
                imr  <= 8'h00;
                ic4  <= bus.io_wdata[0];
                init <= WAIT_ICW2;
            end else begin
                irr <= (irr & ~irr_clr) | edges;
                isr <= (isr & ~eoi_clr) | isr_set;
                if (ack) vec <= ack_hit ? {base, win_idx} : {base, 3'd7};
            end
            if (ocw3 && bus.io_wdata[1]) sel <= bus.io_wdata[0];
            if (data_wr) begin
                case (init)
                    WAIT_ICW2: begin
                        base <= bus.io_wdata[7:3];
                        init <= ic4 ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: begin
`ifdef PIC_AUTO_EOI_EN
                        aeoi <= bus.io_wdata[1];
`endif
                        init <= READY;
                    end
                    READY:   imr  <= bus.io_wdata;
                    default: init <= READY;
                endcase
            end
            if (rd_strobe) rdata <= bus.io_a0 ? imr : (sel ? isr : irr);
        end
    end

    assign bus.intr     = (state == REQ);
    assign bus.vector   = vec;
    assign bus.io_rdata = rdata;

endmodule

// File: tb/tb_pic_master.sv
// ---------------------------------------------------------------------------
// tb_pic_master
// Self-checking bench for pic_master: a table of directed cycles, a few
// hand-written multi-cycle sequences, then randomised traffic compared
// against a behavioural model of the controller.
// Honours PIC_AUTO_EOI_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pic_master;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_CW   = 3'd1;
    localparam logic [2:0] OP_DW   = 3'd2;
    localparam logic [2:0] OP_CR   = 3'd3;
    localparam logic [2:0] OP_DR   = 3'd4;

    typedef struct {
        logic [2:0] op;
        logic [7:0] wd;
        logic [7:0] irq;
        logic       inta;
        logic       intr;
        logic [7:0] vec;
        logic [7:0] rd;
    } vec_t;

    logic clock;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    // Behavioural model state
    logic [7:0] m_irr, m_isr, m_imr, m_prev, m_vec, m_rd;
    logic [4:0] m_base;
    logic       m_sel, m_ic4, m_aeoi, m_req;
    int         m_init;

    pic_master_if bus();

    pic_master dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] wd,
                                input logic [7:0] irq, input logic inta,
                                input logic intr, input logic [7:0] vec,
                                input logic [7:0] rd);
        vec_t v;
        v.op = op; v.wd = wd; v.irq = irq; v.inta = inta;
        v.intr = intr; v.vec = vec; v.rd = rd;
        return v;
    endfunction

    // Controller behaviour from the programmer's view: one call per clock.
    task automatic model_step();
        logic [7:0] d, edges, pend, nirr, nisr;
        int         n;
        bit         ok, ack, icw1, cw, dw, found;
        if (!resetn) begin
            m_irr = 0; m_isr = 0; m_imr = 8'h00; m_prev = 0; m_vec = 8'h08;
            m_rd = 0; m_base = 5'h01; m_sel = 0; m_ic4 = 0; m_aeoi = 0;
            m_req = 0; m_init = 0;
            return;
        end
        d     = bus.io_wdata;
        cw    = bus.io_en && bus.io_wr && !bus.io_a0;
        dw    = bus.io_en && bus.io_wr && bus.io_a0;
        edges = bus.irq_in & ~m_prev;
        pend  = m_irr & ~m_imr;
        n = -1;
        for (int i = 7; i >= 0; i--) if (pend[i]) n = i;
        ok = (n >= 0) && (m_init == 0);
        if (ok) for (int j = 0; j <= n; j++) if (m_isr[j]) ok = 0;
        ack  = bus.inta && m_req;
        icw1 = cw && d[4];
        if (bus.io_en && !bus.io_wr) m_rd = bus.io_a0 ? m_imr : (m_sel ? m_isr : m_irr);
        if (icw1) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_req = 0;
            m_ic4 = d[0]; m_init = 1;
        end else begin
            nirr = m_irr;
            nisr = m_isr;
            if (cw && d[4:3] == 2'b00 && d[7:5] == 3'd1) begin
                found = 0;
                for (int j = 0; j < 8; j++)
                    if (!found && m_isr[j]) begin nisr[j] = 0; found = 1; end
            end
            if (cw && d[4:3] == 2'b00 && d[7:5] == 3'd3) nisr[d[2:0]] = 0;
            if (ack) begin
                if (ok) begin
                    nirr[n] = 0;
                    if (!m_aeoi) nisr[n] = 1;
                    m_vec = {m_base, 3'(n)};
                end else begin
                    m_vec = {m_base, 3'd7};
                end
            end
            m_req = m_req ? (ok && !ack) : ok;
            m_irr = nirr | edges;
            m_isr = nisr;
            if (cw && d[4:3] == 2'b01 && d[1]) m_sel = d[0];
            if (dw) begin
                if (m_init == 1) begin
                    m_base = d[7:3];
                    m_init = m_ic4 ? 2 : 0;
                end else if (m_init == 2) begin
`ifdef PIC_AUTO_EOI_EN
                    m_aeoi = d[1];
`endif
                    m_init = 0;
                end else begin
                    m_imr = d;
                end
            end
        end
        m_prev = bus.irq_in;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [7:0] wd,
                                  input logic [7:0] irq, input logic inta);
        bus.io_en    = (op != OP_NONE);
        bus.io_a0    = (op == OP_DW) || (op == OP_DR);
        bus.io_wr    = (op == OP_CW) || (op == OP_DW);
        bus.io_wdata = wd;
        bus.irq_in   = irq;
        bus.inta     = inta;
    endtask

    task automatic check_output(input string name, input logic [7:0] act,
                                input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        apply_stimulus(OP_NONE, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic check_all(input string tag, input logic intr,
                             input logic [7:0] vec, input logic [7:0] rd);
        check_output({tag, " intr"},   {7'b0, bus.intr}, {7'b0, intr});
        check_output({tag, " vector"}, bus.vector, vec);
        check_output({tag, " rdata"},  bus.io_rdata, rd);
    endtask

    initial begin
        logic [2:0] op;
        logic [7:0] wd, irq;
        logic       inta;
        int         r, k;

        resetn = 1'b0;
        apply_stimulus(OP_NONE, 8'h00, 8'h00, 1'b0);
        do_reset();
        check_all("reset", 1'b0, 8'h08, 8'h00);

        //             op       wd     irq    inta  intr  vec    rd
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h01, 1'b0, 1'b0, 8'h08, 8'h00));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h01, 1'b0, 1'b1, 8'h08, 8'h00));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b1, 1'b0, 8'h08, 8'h00));
        tbl.push_back(mk(OP_CW,   8'h0B, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00));
        tbl.push_back(mk(OP_CR,   8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 8'h01));
        tbl.push_back(mk(OP_CW,   8'h20, 8'h00, 1'b0, 1'b0, 8'h08, 8'h01));
        tbl.push_back(mk(OP_CW,   8'h0A, 8'h00, 1'b0, 1'b0, 8'h08, 8'h01));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h06, 1'b0, 1'b0, 8'h08, 8'h01));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h06, 1'b0, 1'b1, 8'h08, 8'h01));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b1, 1'b0, 8'h09, 8'h01));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b0, 1'b0, 8'h09, 8'h01));
        tbl.push_back(mk(OP_CR,   8'h00, 8'h00, 1'b0, 1'b0, 8'h09, 8'h04));
        tbl.push_back(mk(OP_CW,   8'h20, 8'h00, 1'b0, 1'b0, 8'h09, 8'h04));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b0, 1'b1, 8'h09, 8'h04));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0A, 8'h04));
        tbl.push_back(mk(OP_CW,   8'h20, 8'h00, 1'b0, 1'b0, 8'h0A, 8'h04));
        tbl.push_back(mk(OP_DW,   8'h02, 8'h00, 1'b0, 1'b0, 8'h0A, 8'h04));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h02, 1'b0, 1'b0, 8'h0A, 8'h04));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b0, 1'b0, 8'h0A, 8'h04));
        tbl.push_back(mk(OP_CR,   8'h00, 8'h00, 1'b0, 1'b0, 8'h0A, 8'h02));
        tbl.push_back(mk(OP_DW,   8'h00, 8'h00, 1'b0, 1'b0, 8'h0A, 8'h02));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b0, 1'b1, 8'h0A, 8'h02));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b1, 1'b0, 8'h09, 8'h02));
        tbl.push_back(mk(OP_CW,   8'h20, 8'h00, 1'b0, 1'b0, 8'h09, 8'h02));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h08, 1'b0, 1'b0, 8'h09, 8'h02));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h08, 1'b0, 1'b1, 8'h09, 8'h02));
        tbl.push_back(mk(OP_DW,   8'h08, 8'h08, 1'b0, 1'b1, 8'h09, 8'h02));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0F, 8'h02));
        tbl.push_back(mk(OP_DR,   8'h00, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h08));
        tbl.push_back(mk(OP_CW,   8'h11, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h08));
        tbl.push_back(mk(OP_DW,   8'h70, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h08));
        tbl.push_back(mk(OP_DW,   8'h01, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h08));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h10, 1'b0, 1'b0, 8'h0F, 8'h08));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h10, 1'b0, 1'b1, 8'h0F, 8'h08));
        tbl.push_back(mk(OP_NONE, 8'h00, 8'h00, 1'b1, 1'b0, 8'h74, 8'h08));
        tbl.push_back(mk(OP_CW,   8'h0B, 8'h00, 1'b0, 1'b0, 8'h74, 8'h08));
        tbl.push_back(mk(OP_CR,   8'h00, 8'h00, 1'b0, 1'b0, 8'h74, 8'h10));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i].op, tbl[i].wd, tbl[i].irq, tbl[i].inta);
            tick();
            check_all($sformatf("tbl%0d", i), tbl[i].intr, tbl[i].vec, tbl[i].rd);
        end

        // inta while idle is ignored; ISR (IRQ4 in service) is untouched
        apply_stimulus(OP_NONE, 8'h00, 8'h00, 1'b1);
        tick();
        check_all("idle_inta", 1'b0, 8'h74, 8'h10);
        apply_stimulus(OP_CR, 8'h00, 8'h00, 1'b0);
        tick();
        check_all("idle_inta_isr", 1'b0, 8'h74, 8'h10);

        // IRQ0 pre-empts IRQ4; EOI and acknowledge land in the same cycle
        apply_stimulus(OP_NONE, 8'h00, 8'h01, 1'b0);
        tick();
        tick();
        check_all("nest_req", 1'b1, 8'h74, 8'h10);
        apply_stimulus(OP_CW, 8'h20, 8'h00, 1'b1);
        tick();
        check_all("eoi_ack", 1'b0, 8'h70, 8'h10);
        apply_stimulus(OP_CR, 8'h00, 8'h00, 1'b0);
        tick();
        check_all("eoi_ack_isr", 1'b0, 8'h70, 8'h01);

        // reset beats a simultaneous ICW1, inta and IRQ edges; lines held
        // high through reset release register exactly one edge
        resetn = 1'b0;
        apply_stimulus(OP_CW, 8'h11, 8'hFF, 1'b1);
        tick();
        resetn = 1'b1;
        check_all("rst_override", 1'b0, 8'h08, 8'h00);
        apply_stimulus(OP_NONE, 8'h00, 8'hFF, 1'b0);
        tick();
        check_all("rst_release", 1'b0, 8'h08, 8'h00);
        tick();
        check_all("rst_edge_req", 1'b1, 8'h08, 8'h00);
        apply_stimulus(OP_NONE, 8'h00, 8'hFF, 1'b1);
        tick();
        check_all("rst_edge_ack", 1'b0, 8'h08, 8'h00);
        apply_stimulus(OP_CR, 8'h00, 8'hFF, 1'b0);
        tick();
        check_all("rst_edge_irr", 1'b0, 8'h08, 8'hFE);

        // ICW4 with bit1 set: automatic EOI only when the option is built in
        do_reset();
        apply_stimulus(OP_CW, 8'h13, 8'h00, 1'b0); tick();
        apply_stimulus(OP_DW, 8'h08, 8'h00, 1'b0); tick();
        apply_stimulus(OP_DW, 8'h03, 8'h00, 1'b0); tick();
        apply_stimulus(OP_NONE, 8'h00, 8'h01, 1'b0); tick(); tick();
        check_all("aeoi_req", 1'b1, 8'h08, 8'h00);
        apply_stimulus(OP_NONE, 8'h00, 8'h00, 1'b1); tick();
        check_all("aeoi_ack", 1'b0, 8'h08, 8'h00);
        apply_stimulus(OP_CW, 8'h0B, 8'h00, 1'b0); tick();
        apply_stimulus(OP_CR, 8'h00, 8'h00, 1'b0); tick();
`ifdef PIC_AUTO_EOI_EN
        check_all("aeoi_isr", 1'b0, 8'h08, 8'h00);
`else
        check_all("aeoi_isr", 1'b0, 8'h08, 8'h01);
`endif
        apply_stimulus(OP_NONE, 8'h00, 8'h01, 1'b0); tick(); tick();
`ifdef PIC_AUTO_EOI_EN
        check_all("aeoi_second", 1'b1, 8'h08, 8'h00);
`else
        check_all("aeoi_second", 1'b0, 8'h08, 8'h01);
`endif

        // randomised traffic against the behavioural model
        do_reset();
        irq = 8'h00;
        for (int c = 0; c < 600; c++) begin
            r  = $urandom_range(0, 99);
            wd = 8'($urandom);
            if (r < 10) begin
                op = OP_CW;
                k  = $urandom_range(0, 19);
                if (k == 0)      wd = {3'($urandom), 1'b1, 3'($urandom), 1'($urandom)};
                else if (k < 7)  wd = 8'h20;
                else if (k < 10) wd = {5'b01100, 3'($urandom)};
                else if (k < 12) wd = 8'h0A;
                else if (k < 14) wd = 8'h0B;
                else             wd = wd & 8'hEF;
            end else if (r < 16) begin
                op = OP_DW;
                wd = 8'($urandom) & 8'($urandom);
            end else if (r < 24) op = OP_CR;
            else if (r < 28)     op = OP_DR;
            else                 op = OP_NONE;
            irq  = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            inta = bus.intr ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
            apply_stimulus(op, wd, irq, inta);
            tick();
            check_all($sformatf("rnd%0d", c), m_req, m_vec, m_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
